// File: rtl/pkt_prior_queue.sv
// Header package plus the packet priority queue.
// Each packet's header key is mapped through a programmable table to a class.
// The packet is stored in that class's FIFO, and a strict-priority scheduler
// with an aging guard drains the FIFOs into a valid/ready output register.

package pkt_h;
  // Parsed packet header handed over by the header parser.
  typedef struct packed {
    logic [7:0]  key;
    logic [7:0]  flow;
    logic [15:0] len;
  } pkHeadInfo;
endpackage

module pkt_prior_queue
  import pkt_h::*;
#(
  parameter int DWIDTH       = 64,
  parameter int KEY_WIDTH    = 4,
  parameter int PRIOR_WIDTH  = 2,
  parameter int DEPTH        = 8,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_en,
  output logic                          in_valid,
  input  pkHeadInfo                     in_pkt_info,
  input  logic [DWIDTH-1:0]             in_data,
  input  logic                          cfg_we,
  input  logic [KEY_WIDTH-1:0]          cfg_key,
  input  logic [PRIOR_WIDTH-1:0]        cfg_prior,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [DWIDTH-1:0]             out_data,
  output logic [PRIOR_WIDTH-1:0]        out_prior,
  output logic [(1<<PRIOR_WIDTH)-1:0]   class_full
);

  localparam int NUM_PRIOR = 1 << PRIOR_WIDTH;
  localparam int TBL_SIZE  = 1 << KEY_WIDTH;
  localparam int AW        = $clog2(DEPTH);
  localparam int PW        = AW + 1;
  localparam int AGE_W     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [PRIOR_WIDTH-1:0] prio_tbl [TBL_SIZE];
  logic [DWIDTH-1:0]      mem      [NUM_PRIOR][DEPTH];
  logic [PW-1:0]          wr_ptr   [NUM_PRIOR];
  logic [PW-1:0]          rd_ptr   [NUM_PRIOR];
  logic [AGE_W-1:0]       age      [NUM_PRIOR];

  logic [PRIOR_WIDTH-1:0] in_cls;
  logic                   push;
  logic [NUM_PRIOR-1:0]   empty;
  logic [NUM_PRIOR-1:0]   do_push;
  logic [NUM_PRIOR-1:0]   do_pop;
  logic [NUM_PRIOR-1:0]   full_nxt;
  logic [PRIOR_WIDTH-1:0] sel;
  logic                   any_ne;
  logic                   load;
  logic                   pop;

  // Only the key takes part in classification; the remaining header fields
  // are passed through untouched by this block.
  logic hdr_unused;
  assign hdr_unused = ^in_pkt_info;

  // Class lookup and acceptance; in_valid uses the registered full flag so a
  // full class back-pressures even if it is being drained in the same cycle.
  assign in_cls   = prio_tbl[in_pkt_info.key[KEY_WIDTH-1:0]];
  assign in_valid = !rst && !class_full[in_cls];
  assign push     = in_en && in_valid;

  // Priority table: identity-like mapping after reset, runtime writes after.
  // A packet in the same cycle as a write still sees the old entry.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples values from before the edge, regardless of block order.
    if (rst) begin
      for (int k = 0; k < TBL_SIZE; k++) prio_tbl[k] <= PRIOR_WIDTH'(k);
    end else if (cfg_we) begin
      prio_tbl[cfg_key] <= cfg_prior;
    end
  end

  // Per-class empty flags and strict-priority selection with aging override.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    empty  = '0;
    sel    = '0;
    any_ne = 1'b0;
    for (int c = 0; c < NUM_PRIOR; c++) begin
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
      if (!empty[c]) begin
        any_ne = 1'b1;
        sel    = PRIOR_WIDTH'(c);
      end
    end
    if (STARVE_LIMIT > 0) begin
      for (int c = 0; c < NUM_PRIOR; c++) begin
        if (!empty[c] && age[c] >= AGE_MAX) sel = PRIOR_WIDTH'(c);
      end
    end
  end

  assign load = !out_valid || out_ready;
  assign pop  = load && any_ne;

  // Per-class push/pop strobes and the full flag each FIFO will have next.
  always_comb begin
    logic [PW-1:0] wr_n;
    logic [PW-1:0] rd_n;
    do_push  = '0;
    do_pop   = '0;
    full_nxt = '0;
    wr_n     = '0;
    rd_n     = '0;
    for (int c = 0; c < NUM_PRIOR; c++) begin
      do_push[c]  = push && (in_cls == PRIOR_WIDTH'(c));
      do_pop[c]   = pop && (sel == PRIOR_WIDTH'(c));
      wr_n        = do_push[c] ? wr_ptr[c] + PW'(1) : wr_ptr[c];
      rd_n        = do_pop[c]  ? rd_ptr[c] + PW'(1) : rd_ptr[c];
      full_nxt[c] = (wr_n[PW-1] != rd_n[PW-1]) && (wr_n[AW-1:0] == rd_n[AW-1:0]);
    end
  end

  // FIFO pointers and registered full flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_PRIOR; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
      class_full <= '0;
    end else begin
      for (int c = 0; c < NUM_PRIOR; c++) begin
        if (do_push[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
        if (do_pop[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
      end
      class_full <= full_nxt;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone decide which
    // entries are live, so stale contents are never read.
    if (push) mem[in_cls][wr_ptr[in_cls][AW-1:0]] <= in_data;
  end

  // Output register: refills whenever the slot is free, holds under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_prior <= '0;
    end else if (load) begin
      if (any_ne) begin
        out_valid <= 1'b1;
        out_data  <= mem[sel][rd_ptr[sel][AW-1:0]];
        out_prior <= sel;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Aging: served class clears, bypassed non-empty classes count up to the
  // limit, empty classes sit at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_PRIOR; c++) age[c] <= '0;
    end else if (pop) begin
      for (int c = 0; c < NUM_PRIOR; c++) begin
        if (sel == PRIOR_WIDTH'(c))  age[c] <= '0;
        else if (!empty[c])          age[c] <= (age[c] >= AGE_MAX) ? AGE_MAX : age[c] + AGE_W'(1);
        else                         age[c] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pkt_prior_queue.sv
// Self-checking bench for pkt_prior_queue: directed stimulus with a scoreboard
// queue of expected (data, class) pairs consumed by an output monitor.

module tb_pkt_prior_queue;
  import pkt_h::*;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  prior;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_en;
  logic        in_valid;
  pkHeadInfo   in_pkt_info;
  logic [63:0] in_data;
  logic        cfg_we;
  logic [3:0]  cfg_key;
  logic [1:0]  cfg_prior;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic [1:0]  out_prior;
  logic [3:0]  class_full;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];

  pkt_prior_queue dut (
    .clk        (clk),
    .rst        (rst),
    .in_en      (in_en),
    .in_valid   (in_valid),
    .in_pkt_info(in_pkt_info),
    .in_data    (in_data),
    .cfg_we     (cfg_we),
    .cfg_key    (cfg_key),
    .cfg_prior  (cfg_prior),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_prior  (out_prior),
    .class_full (class_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] tag, input int i);
    return {tag, 24'h0, 32'(i)};
  endfunction

  // Output monitor: a transfer happens at the next rising edge when valid and
  // ready are both high mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_out", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("out_data", out_data, e.data);
        check("out_prior", out_prior, e.prior);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one packet until accepted (bounded); optionally record its
  // expected output in the scoreboard.
  task automatic send(input logic [7:0] k, input logic [63:0] d, input logic [1:0] cls, input bit track);
    bit acc;
    acc = 1'b0;
    if (track) expq.push_back('{data: d, prior: cls});
    in_en           = 1'b1;
    in_pkt_info     = '0;
    in_pkt_info.key = k;
    in_data         = d;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = in_valid;
      tick();
    end
    in_en = 1'b0;
    check("send_accept", acc, 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 400 && expq.size() != 0; t++) @(posedge clk);
    #1;
    check(tag, expq.size(), 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    in_en       = 1'b0;
    in_pkt_info = '0;
    in_data     = '0;
    cfg_we      = 1'b0;
    cfg_key     = '0;
    cfg_prior   = '0;
    out_ready   = 1'b0;

    // Reset state
    tick();
    @(negedge clk);
    check("rst_in_valid", in_valid, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_out_prior", out_prior, 2'd0);
    check("rst_class_full", class_full, 4'h0);
    tick();
    rst = 1'b0;

    // Test 1: keys 1..7 back to back, latency of the first packet
    out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      logic [1:0] cls;
      cls             = 2'(i);
      in_en           = 1'b1;
      in_pkt_info     = '0;
      in_pkt_info.key = 8'(i);
      in_data         = mk(8'hA1, i);
      expq.push_back('{data: in_data, prior: cls});
      @(negedge clk);
      check("t1_in_valid", in_valid, 1'b1);
      if (i == 1) check("t1_lat_before", out_valid, 1'b0);
      if (i == 2) check("t1_lat_one", out_valid, 1'b0);
      if (i == 3) check("t1_lat_two", out_valid, 1'b1);
      tick();
    end
    in_en = 1'b0;
    drain("t1_drain");

    // Test 2: strict priority, class 3 before class 1, hold under stall
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(8'd3, mk(8'hB3, i), 2'd3, 1'b1);
    for (int i = 0; i < 3; i++) send(8'd1, mk(8'hB1, i), 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_hold_valid", out_valid, 1'b1);
      check("t2_hold_data", out_data, mk(8'hB3, 0));
      tick();
    end
    out_ready = 1'b1;
    drain("t2_drain");

    // Test 3: fill class 2 to DEPTH behind an occupied output slot
    out_ready = 1'b0;
    send(8'd1, mk(8'hC1, 0), 2'd1, 1'b1);
    for (int i = 0; i < 8; i++) send(8'd2, mk(8'hC2, i), 2'd2, 1'b1);
    @(negedge clk);
    check("t3_class_full", class_full, 4'b0100);
    tick();
    in_en           = 1'b1;
    in_pkt_info     = '0;
    in_pkt_info.key = 8'd2;
    in_data         = mk(8'hCF, 0);
    @(negedge clk);
    check("t3_blocked", in_valid, 1'b0);
    tick();
    in_en = 1'b0;
    send(8'd1, mk(8'hC1, 1), 2'd1, 1'b1);
    out_ready = 1'b1;
    drain("t3_drain");

    // Test 4: table write with a same-cycle packet (old entry), then new entry
    cfg_we    = 1'b1;
    cfg_key   = 4'd5;
    cfg_prior = 2'd2;
    tick();
    cfg_we          = 1'b1;
    cfg_key         = 4'd5;
    cfg_prior       = 2'd0;
    in_en           = 1'b1;
    in_pkt_info     = '0;
    in_pkt_info.key = 8'd5;
    in_data         = mk(8'hD5, 0);
    expq.push_back('{data: in_data, prior: 2'd2});
    @(negedge clk);
    check("t4_in_valid", in_valid, 1'b1);
    tick();
    cfg_we = 1'b0;
    in_en  = 1'b0;
    send(8'd5, mk(8'hD5, 1), 2'd0, 1'b1);
    drain("t4_drain");

    // Test 5: aging forces the lone class-0 packet out after 15 class-3 pops
    out_ready = 1'b0;
    for (int i = 0; i <= 15; i++) expq.push_back('{data: mk(8'hE3, i), prior: 2'd3});
    expq.push_back('{data: mk(8'hE0, 0), prior: 2'd0});
    for (int i = 16; i <= 21; i++) expq.push_back('{data: mk(8'hE3, i), prior: 2'd3});
    send(8'd3, mk(8'hE3, 0), 2'd3, 1'b0);
    send(8'd3, mk(8'hE3, 1), 2'd3, 1'b0);
    send(8'd4, mk(8'hE0, 0), 2'd0, 1'b0);
    for (int i = 2; i <= 8; i++) send(8'd3, mk(8'hE3, i), 2'd3, 1'b0);
    out_ready = 1'b1;
    for (int i = 9; i <= 21; i++) send(8'd3, mk(8'hE3, i), 2'd3, 1'b0);
    drain("t5_drain");

    // Test 6: reset with packets buffered; packet and cfg write in reset discarded
    out_ready = 1'b0;
    send(8'd3, mk(8'hF0, 0), 2'd3, 1'b0);
    send(8'd1, mk(8'hF0, 1), 2'd1, 1'b0);
    send(8'd2, mk(8'hF0, 2), 2'd2, 1'b0);
    send(8'd4, mk(8'hF0, 3), 2'd0, 1'b0);
    rst             = 1'b1;
    in_en           = 1'b1;
    in_pkt_info     = '0;
    in_pkt_info.key = 8'd3;
    in_data         = mk(8'hFF, 9);
    cfg_we          = 1'b1;
    cfg_key         = 4'd6;
    cfg_prior       = 2'd0;
    @(negedge clk);
    check("t6_rst_in_valid", in_valid, 1'b0);
    tick();
    rst    = 1'b0;
    in_en  = 1'b0;
    cfg_we = 1'b0;
    @(negedge clk);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_class_full", class_full, 4'h0);
    check("t6_out_data", out_data, 64'h0);
    tick();
    out_ready = 1'b1;
    send(8'd5, mk(8'hA6, 0), 2'd1, 1'b1);
    send(8'd6, mk(8'hA6, 1), 2'd2, 1'b1);
    send(8'd3, mk(8'hA6, 2), 2'd3, 1'b1);
    drain("t6_drain");
    @(negedge clk);
    check("t6_idle", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
